// File: rtl/bnn_conv_window.sv
// rtl/bnn_conv_window.sv - streaming 5x5 binary-weight convolution window engine; CONV_SAT_EN selects saturation over wrap
module bnn_conv_window #(
  parameter int DATA_W = 32,
  parameter int K      = 5,
  parameter int IMG_W0 = 28,
  parameter int IMG_W1 = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              weight_en,
  input  logic              weight,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              state,
  output logic [DATA_W-1:0] dout,
  output logic              ovalid,
  output logic              done
);

  localparam int NTAP  = K * K;
  localparam int ACC_W = DATA_W + 5;
  localparam int PROD_W = DATA_W + 1;
  localparam int LB_D  = (IMG_W0 > IMG_W1) ? IMG_W0 : IMG_W1;
  localparam int CW    = $clog2(LB_D);
  localparam int WCW   = $clog2(NTAP + 1);
  localparam int NOUT0 = (IMG_W0 - K + 1) * (IMG_W0 - K + 1);
  localparam int NOUT1 = (IMG_W1 - K + 1) * (IMG_W1 - K + 1);
  localparam int NOUTM = (NOUT0 > NOUT1) ? NOUT0 : NOUT1;
  localparam int OCW   = $clog2(NOUTM + 1);

  // weight store and load pointer
  logic [NTAP-1:0]   r_weights;
  logic [WCW-1:0]    r_wcnt;

  // raster position of the pixel currently presented on din
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;

  // line buffers: r_lb[0] holds the previous row, r_lb[K-2] the oldest
  logic [DATA_W-1:0] r_lb  [K-1][LB_D];
  logic [DATA_W-1:0] r_win [K][K];
  logic              r_v0;

  // weighted taps, one bit wider so negating the most negative pixel is exact
  logic [PROD_W-1:0] r_prod [NTAP];
  logic              r_v1;

  logic [OCW-1:0]    r_ocnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_ovalid;
  logic              r_done;

  logic [CW-1:0]     w_img_w;
  logic [OCW-1:0]    w_nout;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_win_ok;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_col [K];
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_res;

  assign w_img_w     = state ? CW'(IMG_W1) : CW'(IMG_W0);
  assign w_nout      = state ? OCW'(NOUT1) : OCW'(NOUT0);
  assign w_accept    = start & din_valid;
  assign w_last_col  = (r_col == w_img_w - CW'(1));
  assign w_last_row  = (r_row == w_img_w - CW'(1));
  assign w_win_ok    = (r_row >= CW'(K - 1)) && (r_col >= CW'(K - 1));
  assign w_frame_end = w_accept & w_last_col & w_last_row;

  // column tap for the incoming pixel: top entry is K-1 rows back, bottom is din
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      w_col[r] = r_lb[K-2-r][r_col];
    end
    w_col[K-1] = din;
  end

  // weight loading: bits beyond the kernel size are dropped, pointer rewinds when the strobe drops
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_weights <= '0;
      r_wcnt    <= '0;
    end else if (weight_en) begin
      if (r_wcnt < WCW'(NTAP)) begin
        r_weights[r_wcnt] <= weight;
        r_wcnt            <= r_wcnt + WCW'(1);
      end
    end else begin
      r_wcnt <= '0;
    end
  end

  // row/column tracking; wraps to the frame origin after the last pixel
  always_ff @(posedge clk) begin
    if (!rstn || !start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // line buffers shift one row down per column slot; cleared between frames so each frame primes from zero
  always_ff @(posedge clk) begin
    if (!rstn || !start || w_frame_end) begin
      for (int k = 0; k < K - 1; k++) begin
        for (int c = 0; c < LB_D; c++) begin
          r_lb[k][c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_lb[0][r_col] <= din;
      for (int k = 1; k < K - 1; k++) begin
        r_lb[k][r_col] <= r_lb[k-1][r_col];
      end
    end
  end

  // window register: shift left one column and insert the new column tap
  always_ff @(posedge clk) begin
    if (!rstn || !start) begin
      r_v0 <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_v0 <= w_accept & w_win_ok;
      if (w_accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
          r_win[r][K-1] <= w_col[r];
        end
      end
    end
  end

  // negate or pass each window tap according to its weight bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_v1 <= start & r_v0;
      if (r_v0) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            r_prod[r*K+c] <= r_weights[r*K+c] ?  {r_win[r][c][DATA_W-1], r_win[r][c]}
                                              : -{r_win[r][c][DATA_W-1], r_win[r][c]};
          end
        end
      end
    end
  end

  // wide sum of all weighted taps
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NTAP; i++) begin
      w_sum = w_sum + {{(ACC_W-PROD_W){r_prod[i][PROD_W-1]}}, r_prod[i]};
    end
  end

`ifdef CONV_SAT_EN
  logic [ACC_W-DATA_W:0] w_hi;
  assign w_hi  = w_sum[ACC_W-1:DATA_W-1];
  assign w_res = ((&w_hi) || !(|w_hi)) ? w_sum[DATA_W-1:0]
               : (w_sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_sum[ACC_W-1:DATA_W];
  assign w_res       = w_sum[DATA_W-1:0];
`endif

  // output register; result count raises done on the last window of the frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dout   <= '0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
      r_ocnt   <= '0;
    end else if (!start) begin
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
      r_ocnt   <= '0;
    end else begin
      r_ovalid <= r_v1;
      r_done   <= 1'b0;
      if (r_v1) begin
        r_dout <= w_res;
        if (r_ocnt == w_nout - OCW'(1)) begin
          r_done <= 1'b1;
          r_ocnt <= '0;
        end else begin
          r_ocnt <= r_ocnt + OCW'(1);
        end
      end
    end
  end

  assign dout   = r_dout;
  assign ovalid = r_ovalid;
  assign done   = r_done;

endmodule

// File: tb/tb_bnn_conv_window.sv
// tb/tb_bnn_conv_window.sv - self-checking bench for bnn_conv_window
`timescale 1ns/1ps
module tb_bnn_conv_window;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn, start, weight_en, weight, din_valid, state;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          ovalid, done;

  always #5 clk = ~clk;

  bnn_conv_window dut (
    .clk(clk), .rstn(rstn), .start(start), .weight_en(weight_en), .weight(weight),
    .din_valid(din_valid), .din(din), .state(state),
    .dout(dout), .ovalid(ovalid), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] val;
    bit            last;
  } exp_t;

  typedef struct {
    bit            st;
    logic [24:0]   w;
    int            extra;
    int            mode;   // 0 constant, 1 ramp W*r+c, 2 small random, 3 full random
    logic [DW-1:0] cval;
    int            gap;    // percent chance of an idle cycle before a pixel
    int            n_exp;
    bit            chk_fl;
    logic [DW-1:0] first_exp;
    logic [DW-1:0] last_exp;
  } vec_t;

  logic [24:0]   wts;
  logic [DW-1:0] img [28][28];
  exp_t          expq[$];

  bit            mon_check = 1'b0;
  int            n_ov, n_done, first_cyc;
  logic [DW-1:0] first_val, last_val;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] fold(input longint s);
`ifdef CONV_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ovalid) begin
      n_ov++;
      if (n_ov == 1) begin
        first_cyc = cyc;
        first_val = dout;
      end
      last_val = dout;
      if (done) n_done++;
      if (mon_check) begin
        if (expq.size() == 0) begin
          check("ovalid_unexpected", ovalid, 0);
        end else begin
          e = expq.pop_front();
          check("dout", dout, e.val);
          check("done_flag", done, e.last);
        end
      end
    end else if (done) begin
      check("done_without_ovalid", ovalid, 1);
    end
  end

  task automatic load_weights(input logic [24:0] w, input int extra);
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      weight_en = 1'b1;
      weight    = w[i];
      @(negedge clk);
    end
    for (int i = 0; i < extra; i++) begin
      weight_en = 1'b1;
      weight    = ~w[i];
      @(negedge clk);
    end
    weight_en = 1'b0;
    weight    = 1'b0;
    wts       = w;
  endtask

  task automatic run_frame(input string name, input bit st, input int mode, input logic [DW-1:0] cval,
                           input int gap, input int n_exp, input bit chk_fl,
                           input logic [DW-1:0] first_exp, input logic [DW-1:0] last_exp);
    int     w;
    int     acc_cyc;
    int     t;
    longint s, p;
    exp_t   e;
    w = st ? 12 : 28;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        case (mode)
          0:       img[r][c] = cval;
          1:       img[r][c] = DW'(w * r + c);
          2:       img[r][c] = DW'($urandom_range(0, 2000)) - 32'd1000;
          default: img[r][c] = $urandom;
        endcase
      end
    end
    expq.delete();
    for (int i = 0; i <= w - 5; i++) begin
      for (int j = 0; j <= w - 5; j++) begin
        s = 0;
        for (int a = 0; a < 5; a++) begin
          for (int b = 0; b < 5; b++) begin
            p = longint'($signed(img[i+a][j+b]));
            s = wts[a*5+b] ? s + p : s - p;
          end
        end
        e.val  = fold(s);
        e.last = (i == w - 5) && (j == w - 5);
        expq.push_back(e);
      end
    end
    state     = st;
    start     = 1'b1;
    n_ov      = 0;
    n_done    = 0;
    acc_cyc   = 0;
    mon_check = 1'b1;
    for (int pix = 0; pix < w * w; pix++) begin
      t = 0;
      while (gap > 0 && t < 8 && $urandom_range(0, 99) < gap) begin
        din_valid = 1'b0;
        t++;
        @(negedge clk);
      end
      din_valid = 1'b1;
      din       = img[pix / w][pix % w];
      if (pix == 4 * w + 4) acc_cyc = cyc + 1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    for (t = 0; t < 20 && expq.size() > 0; t++) @(negedge clk);
    check({name, "_queue_drained"}, expq.size(), 0);
    repeat (4) @(negedge clk);
    mon_check = 1'b0;
    check({name, "_count"}, n_ov, n_exp);
    check({name, "_done_count"}, n_done, 1);
    check({name, "_latency"}, first_cyc - acc_cyc, 2);
    if (chk_fl) begin
      check({name, "_first"}, first_val, first_exp);
      check({name, "_last"}, last_val, last_exp);
    end
    expq.delete();
  endtask

  task automatic stream_partial(input bit st, input int npix, input logic [DW-1:0] val, input bit en);
    state     = st;
    start     = en;
    mon_check = 1'b0;
    n_ov      = 0;
    n_done    = 0;
    for (int pix = 0; pix < npix; pix++) begin
      din_valid = 1'b1;
      din       = val;
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    vec_t          v[10];
    logic [DW-1:0] big_exp;
`ifdef CONV_SAT_EN
    big_exp = 32'h7FFFFFFF;
`else
    big_exp = 32'h7FFFFFE7;
`endif
    v[0] = '{0, '1, 0, 0, 32'd1,          0,  576, 1, 32'd25,         32'd25};
    v[1] = '{0, '0, 0, 0, 32'd1,          0,  576, 1, 32'hFFFFFFE7,   32'hFFFFFFE7};
    v[2] = '{0, '1, 0, 1, 32'd0,          0,  576, 1, 32'd1450,       32'd18125};
    v[3] = '{1, '1, 0, 0, 32'd1,          0,  64,  1, 32'd25,         32'd25};
    v[4] = '{1, '1, 0, 0, 32'd1,          0,  64,  1, 32'd25,         32'd25};
    v[5] = '{1, '1, 0, 0, 32'h7FFFFFFF,   0,  64,  1, big_exp,        big_exp};
    v[6] = '{1, '1, 5, 0, 32'd1,          0,  64,  1, 32'd25,         32'd25};
    v[7] = '{1, 25'($urandom), 0, 2, 32'd0, 30, 64,  0, 32'd0,       32'd0};
    v[8] = '{0, 25'($urandom), 0, 3, 32'd0, 20, 576, 0, 32'd0,       32'd0};
    v[9] = '{1, 25'($urandom), 0, 3, 32'd0, 0,  64,  0, 32'd0,       32'd0};

    rstn = 1'b0; start = 1'b0; weight_en = 1'b0; weight = 1'b0;
    din_valid = 1'b0; din = '0; state = 1'b0; wts = '0;
    n_ov = 0; n_done = 0; first_cyc = 0; first_val = '0; last_val = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_ovalid", ovalid, 0);
    check("reset_done", done, 0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      load_weights(v[i].w, v[i].extra);
      run_frame($sformatf("vec%0d", i), v[i].st, v[i].mode, v[i].cval, v[i].gap,
                v[i].n_exp, v[i].chk_fl, v[i].first_exp, v[i].last_exp);
    end

    // pixels offered while the engine is disabled are dropped
    stream_partial(1'b0, 200, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("idle_no_ovalid", n_ov, 0);
    run_frame("after_idle", 1'b0, 2, 32'd0, 10, 576, 1'b0, 32'd0, 32'd0);

    // reset in the middle of a frame: no done, weights return to all -1
    load_weights('1, 0);
    stream_partial(1'b0, 300, 32'd1, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_rst_dout", dout, 0);
    check("abort_rst_ovalid", ovalid, 0);
    repeat (5) @(negedge clk);
    check("abort_rst_outputs_seen", n_ov > 0, 1);
    check("abort_rst_no_done", n_done, 0);
    wts = '0;
    run_frame("post_rst_cleared_w", 1'b1, 0, 32'd1, 0, 64, 1'b1, 32'hFFFFFFE7, 32'hFFFFFFE7);
    load_weights('1, 0);
    run_frame("post_rst_full", 1'b0, 0, 32'd1, 0, 576, 1'b1, 32'd25, 32'd25);

    // dropping start mid-frame aborts without done
    stream_partial(1'b0, 400, 32'd5, 1'b1);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_start_no_done", n_done, 0);
    load_weights(25'($urandom), 0);
    run_frame("post_start_abort", 1'b1, 2, 32'd0, 25, 64, 1'b0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_conv_window.md
Name: bnn_conv_window

Overview:
- Streaming 5x5 binary-weight convolution engine for the BNN datapath.
- A line-buffer window generator turns a raster pixel stream into 5x5 neighbourhoods. A MAC stage adds or subtracts each pixel according to a 1-bit weight.
- Two layer modes:
  - state=0: 28x28 input producing 24x24 output.
  - state=1: 12x12 input producing 8x8 output.
- Sits between the image/pool buffer and the downstream activation/pooling stage.

Parameters:
- DATA_W, 32, signed pixel and result width.
- K, 5, kernel size (K x K).
- IMG_W0, 28, input width/height when state=0.
- IMG_W1, 12, input width/height when state=1.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset: one clock; reset is synchronous and active-low.
- start  in  1  engine enable; low = idle, all counters cleared.
- weight_en  in  1  weight load strobe; one weight bit per cycle.
- weight  in  1  binary weight: 1 = +1, 0 = -1.
- din_valid  in  1  pixel strobe; din sampled when high.
- din  in  DATA_W  signed pixel, raster order (row-major).
- state  in  1  layer select: 0 = 28x28, 1 = 12x12. Held static for a whole frame.
- dout  out  DATA_W  signed conv result.
- ovalid  out  1  dout valid, one-cycle pulse per result.
- done  out  1  high with the last result of a frame.

Behaviour:
- Reset (rstn=0 at posedge):
  - dout=0, ovalid=0, done=0.
  - Pixel, row, column, output and weight-load counters cleared.
  - Line buffers and window registers cleared.
  - Weight register cleared to all 0, i.e. all -1.
- Weight load:
  - Each cycle with weight_en=1, the bit is stored at index wcnt; wcnt increments.
  - Index mapping: index 0 = kernel (0,0); row-major up to index 24 = (4,4).
  - Bits beyond 25 are ignored.
  - wcnt clears whenever weight_en=0.
  - Loading and pixel streaming may overlap. Weights must be complete before the first window is valid.
- Window generation:
  - W = IMG_W0 or IMG_W1 per state.
  - K-1 line buffers of W pixels each form a column tap {p[n], p[n-W], p[n-2W], p[n-3W], p[n-4W]} on each accepted pixel.
  - The column shifts into a 5x5 window register.
  - Row/col counters track position of pixel n.
- Validity: a window is valid on the cycle pixel n is accepted with row>=4 and col>=4.
  - Yields (W-4)^2 outputs per frame: 576 or 64.
  - No valid outputs from wrap-around columns (col<4).
- Arithmetic:
  - sum = Σ (w ? +p : -p) over 25 taps.
  - Accumulated in DATA_W+5 bits, then truncated to DATA_W (two's-complement wrap).
- Latency: dout/ovalid appear exactly 2 cycles after the posedge accepting the completing pixel (stage 1: window/negate register; stage 2: adder tree register).
  - Back-to-back pixels give back-to-back results.
  - Gaps in din_valid propagate as gaps in ovalid.
- done:
  - Asserted together with ovalid on the final result (576th or 64th); one cycle only.
  - Pixel/output counters then clear; the next frame starts on the next din_valid with line buffers re-primed from zero.
  - Weights persist.
- Boundary cases:
  - start=0 or rstn=0 mid-frame: frame aborted, counters cleared, no done.
  - din_valid while start=0: ignored.
  - Pixels beyond W*W in a frame: not possible, since counters wrap at done.
  - dout holds its last value when ovalid=0.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: the wide sum is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before output.
- Undefined: plain truncation to DATA_W bits (wrap).
- Latency is identical in both cases.

Test Plan:
- All weights 1, state=0, 784 pixels all 1 -> 576 ovalid pulses, each dout=25; done high only on the 576th.
- All weights 0, same image -> 576 results each -25; done on the last.
- All weights 1, state=0, pixel(r,c)=28r+c -> dout(i,j)=1450+25*(28i+j); first=1450, last=1450+25*(28*23+23)=18125.
- state=1, all weights 1, 144 pixels of 1 -> 64 results of 25; done on the 64th; a second frame repeats identically.
- Deassert rstn after 300 pixels, then re-stream a full frame -> no done from the aborted frame; the new frame gives exactly 576 correct results.
- All weights 1, all pixels 0x7FFFFFFF -> CONV_SAT_EN defined: 0x7FFFFFFF; undefined: 0x7FFFFFE7.
